camera_pixel_source: RTL
========================

# camera_pixel_source

Synthesizable pixel-stream transmitter that drives the parallel camera port (Vsync, Href, Pclk, 8-bit data) with OV7670-style frame timing. It is the source end of the interface consumed by the Wishbone camera capture block. It is used as an on-chip camera substitute for bring-up and as the stimulus engine in capture-path benches. Four selectable test patterns, single-shot or continuous frames.

## Interface
- H_ACTIVE, 640: pixels (bytes) per line with Href high
- H_BLANK, 144: Pclk periods per line with Href low
- V_SYNC, 3: lines with Vsync high
- V_BACK, 17: lines between Vsync fall and first active line
- V_ACTIVE, 480: active lines per frame
- V_FRONT, 10: lines after last active line
- clk  in  1  system clock; one clock domain, asynchronous active-high reset
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately
- start  in  1  one-cycle request to emit a frame; ignored while busy
- continuous  in  1  when high at frame end, next frame begins without start
- pattern  in  2  pattern select, latched at frame start
- camera_Pclk  out  1  pixel clock, clk/2 while busy, 0 when idle
- camera_Vsync  out  1  frame sync, active high
- camera_Href  out  1  line valid, active high
- Imagen  out  8  pixel byte, 0 whenever Href is low
- busy  out  1  high from frame start through last front-porch Pclk period
- frame_done  out  1  one-clk pulse at frame end

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- IDLE: Pclk held 0. start=1 -> latch pattern, enter VSYNC, busy=1.
- Line = H_ACTIVE+H_BLANK Pclk periods. Column counter hcnt counts 0..LINE-1. Line counter vcnt counts within the current state.
- VSYNC: Vsync=1 for V_SYNC lines -> VBACK (V_BACK lines) -> ACTIVE (V_ACTIVE lines) -> VFRONT (V_FRONT lines).
- ACTIVE: Href=1 for hcnt < H_ACTIVE. Here x=hcnt and y=active line index.
- Patterns: 0 -> x[7:0]; 1 -> y[7:0]; 2 -> 8'hFF if x[3]^y[3] else 8'h00; 3 -> constant 8'hA5.
- End of VFRONT: frame_done=1 for one clk. If continuous=1, relatch pattern and enter VSYNC. Otherwise go to IDLE with busy=0.
- start during busy is ignored. start and frame end in the same clk behave as if continuous=1.
- Counter widths are $clog2 of the respective maximum. Counters must not overflow: they wrap only at their terminal counts.

## Timing
- Reset values: camera_Pclk, camera_Vsync, camera_Href, Imagen, busy, frame_done all 0. State is IDLE.
- The clk edge after start: state=VSYNC, Vsync=1, busy=1, Pclk=0. Pclk toggles every clk thereafter, so the period is 2 clks.
- Vsync, Href, Imagen and all counters update only on the clk edge that drives Pclk 1->0. They are stable across each Pclk rising edge, where the receiver samples.
- Pixel N of a line is valid for the Pclk rising edge N (0-based) after Href rises.
- Frame length = (V_SYNC+V_BACK+V_ACTIVE+V_FRONT) × LINE × 2 clks.
- frame_done is asserted on the clk edge that completes the final falling Pclk of VFRONT.
- Continuous mode: VSYNC of the next frame follows with no idle gap.
- Reset mid-frame: outputs go to 0 asynchronously. No frame_done is emitted, and the block waits for start.

## Structure
- Package camera_pixel_source_pkg: the state enum and the pattern codes PAT_XRAMP=0, PAT_YRAMP=1, PAT_CHECK=2, PAT_CONST=3. Also holds the constant CONST_PIXEL=8'hA5.
- Sub-module camera_pattern_gen: pure combinational (pattern, x, y, href) -> pixel byte. The top holds the FSM, counters and Pclk divider.

## Test plan
- Params H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1, pattern=0, one start pulse -> Vsync high for 12 Pclk periods. Two Href bursts of 8 bytes, each 00..07. frame_done once, exactly 120 clks after start. Then busy=0 and Pclk static 0.
- Same params, pattern=2 -> line 0 bytes 00×8, line 1 bytes 00×8 (x[3]=y[3]=0). With H_ACTIVE=16 -> line 0 = 00×8 then FF×8.
- continuous=1 with pattern changed mid-frame from 1 to 3 -> first frame carries y ramp (00s then 01s). The next frame starts immediately after frame_done, with all bytes A5.
- start pulsed mid-frame -> no effect on timing or counters. Frame count is unchanged.
- reset asserted during ACTIVE -> all outputs 0 within the same cycle, no frame_done. A new start produces a full, correct frame.
- Check at every Pclk rising edge that Imagen, Href and Vsync were stable in the preceding clk, and that Imagen=0 whenever Href=0.

Source files
------------

// File: rtl/camera_pixel_source_pkg.sv
// Shared types and constants for the camera pixel source.
package camera_pixel_source_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } cps_state_t;

    typedef enum logic [1:0] {
        PAT_XRAMP = 2'd0,
        PAT_YRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_CONST = 2'd3
    } pattern_t;

    localparam logic [7:0] CONST_PIXEL = 8'hA5;

    // Bits needed to count 0..max_count-1, never less than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// Combinational test-pattern generator: pixel byte from pattern, column and line.
module camera_pattern_gen
    import camera_pixel_source_pkg::*;
(
    input  pattern_t   pattern,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       href,
    output logic [7:0] pixel
);

    // Pixel value is forced to zero outside the active part of a line.
    always_comb begin
        pixel = 8'h00;
        if (href) begin
            case (pattern)
                PAT_XRAMP: pixel = x;
                PAT_YRAMP: pixel = y;
                PAT_CHECK: pixel = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
                PAT_CONST: pixel = CONST_PIXEL;
            endcase
        end
    end

endmodule

// File: rtl/camera_pixel_source.sv
// OV7670-style parallel camera transmitter: frame FSM, line/column counters,
// Pclk divider. Outputs change only on the clk edge that drives Pclk low.
//
// state     | meaning
// ST_IDLE   | waiting for start, Pclk held low
// ST_VSYNC  | Vsync high for V_SYNC lines
// ST_VBACK  | vertical back porch
// ST_ACTIVE | active lines, Href high for the first H_ACTIVE columns
// ST_VFRONT | vertical front porch, frame ends after its last Pclk period
module camera_pixel_source
    import camera_pixel_source_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic [1:0] pattern,
    output logic       camera_Pclk,
    output logic       camera_Vsync,
    output logic       camera_Href,
    output logic [7:0] Imagen,
    output logic       busy,
    output logic       frame_done
);

    localparam int LINE  = H_ACTIVE + H_BLANK;
    localparam int V_M1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_M2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int HW    = cnt_width(LINE);
    localparam int VW    = cnt_width(V_MAX);

    localparam logic [HW-1:0] H_LAST = HW'(LINE - 1);

    cps_state_t    state, nxt_state;
    logic [HW-1:0] hcnt, nxt_hcnt;
    logic [VW-1:0] vcnt, nxt_vcnt, v_last;
    pattern_t      pat_q, nxt_pat;
    logic          end_frame;
    logic          nxt_href;
    logic [7:0]    nxt_pixel;

    // Terminal line count of the current vertical region.
    always_comb begin
        v_last = '0;
        case (state)
            ST_VSYNC:  v_last = VW'(V_SYNC - 1);
            ST_VBACK:  v_last = VW'(V_BACK - 1);
            ST_ACTIVE: v_last = VW'(V_ACTIVE - 1);
            ST_VFRONT: v_last = VW'(V_FRONT - 1);
            default:   v_last = '0;
        endcase
    end

    // Next state and counters; timing advances only when Pclk is about to fall.
    always_comb begin
        nxt_state = state;
        nxt_hcnt  = hcnt;
        nxt_vcnt  = vcnt;
        nxt_pat   = pat_q;
        end_frame = 1'b0;
        if (state == ST_IDLE) begin
            if (start) begin
                nxt_state = ST_VSYNC;
                nxt_hcnt  = '0;
                nxt_vcnt  = '0;
                nxt_pat   = pattern_t'(pattern);
            end
        end else if (camera_Pclk) begin
            if (hcnt == H_LAST) begin
                nxt_hcnt = '0;
                if (vcnt == v_last) begin
                    nxt_vcnt = '0;
                    case (state)
                        ST_VSYNC:  nxt_state = ST_VBACK;
                        ST_VBACK:  nxt_state = ST_ACTIVE;
                        ST_ACTIVE: nxt_state = ST_VFRONT;
                        default: begin
                            end_frame = 1'b1;
                            // A start coinciding with frame end chains like continuous mode.
                            if (continuous || start) begin
                                nxt_state = ST_VSYNC;
                                nxt_pat   = pattern_t'(pattern);
                            end else begin
                                nxt_state = ST_IDLE;
                            end
                        end
                    endcase
                end else begin
                    nxt_vcnt = vcnt + 1'b1;
                end
            end else begin
                nxt_hcnt = hcnt + 1'b1;
            end
        end
    end

    assign nxt_href = (nxt_state == ST_ACTIVE) && (32'(nxt_hcnt) < H_ACTIVE);

    camera_pattern_gen u_pattern_gen (
        .pattern (nxt_pat),
        .x       (8'(nxt_hcnt)),
        .y       (8'(nxt_vcnt)),
        .href    (nxt_href),
        .pixel   (nxt_pixel)
    );

    // State, counters and all port outputs registered from the next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            hcnt         <= '0;
            vcnt         <= '0;
            pat_q        <= PAT_XRAMP;
            camera_Pclk  <= 1'b0;
            camera_Vsync <= 1'b0;
            camera_Href  <= 1'b0;
            Imagen       <= 8'h00;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= nxt_state;
            hcnt         <= nxt_hcnt;
            vcnt         <= nxt_vcnt;
            pat_q        <= nxt_pat;
            camera_Pclk  <= (state != ST_IDLE) ? ~camera_Pclk : 1'b0;
            camera_Vsync <= (nxt_state == ST_VSYNC);
            camera_Href  <= nxt_href;
            Imagen       <= nxt_pixel;
            busy         <= (nxt_state != ST_IDLE);
            frame_done   <= end_frame;
        end
    end

endmodule
